pix_fifo_writer: RTL and testbench

//  Upstream feeder for the dual-bank word FIFO. Single clock domain.

---
 rtl/pix_fifo_writer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_pix_fifo_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : pix_fifo_writer
// Purpose  : Frames a raw 12-bit pixel stream for the dual-bank word FIFO.
//            Each frame is written as a header word, one zero-extended word
//            per accepted pixel, then a 3-word trailer (pixel count low,
//            pixel count high, 16-bit checksum). Words are offered through a
//            trigger/done handshake. FIFO stalls are absorbed by a small
//            pixel queue; pixels arriving while the queue is full are
//            dropped and flagged.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            pix_frame_start_i         1-cycle frame start pulse
//            pix_frame_end_i           1-cycle frame end pulse
//            pix_valid_i, pix_data_i   pixel strobe and 12-bit value
//            w_trigger_o, w_data_o     registered word offer to the FIFO
//            w_done_i                  FIFO accepted the offered word
//            busy_o                    frame in progress (state != IDLE)
//            overflow_o                sticky pixel-drop flag for the frame
//            frame_count_o             completed frames, wraps at 2^16
// Revision : 1.0  initial release
// ============================================================================
module pix_fifo_writer #(
    parameter int          D   = 2,
    parameter logic [15:0] HDR = 16'hA5F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_frame_start_i,
    input  logic        pix_frame_end_i,
    input  logic        pix_valid_i,
    input  logic [11:0] pix_data_i,
    output logic        w_trigger_o,
    output logic [15:0] w_data_o,
    input  logic        w_done_i,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [15:0] frame_count_o
);

    localparam int         DEPTH  = 1 << D;
    localparam logic [D:0] C_FULL = (D + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_PIX    = 3'd2,
        ST_CNT_LO = 3'd3,
        ST_CNT_HI = 3'd4,
        ST_SUM    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic        trig_q,     trig_d;
    logic [15:0] data_q,     data_d;
    logic        end_seen_q, end_seen_d;
    logic        ovf_q,      ovf_d;
    logic [15:0] fcnt_q,     fcnt_d;
    logic [31:0] pcnt_q,     pcnt_d;
    logic [15:0] sum_q,      sum_d;

    // Pixel queue: circular buffer with occupancy counter
    logic [11:0] mem_q [DEPTH];
    logic [D-1:0] wr_ptr_q, wr_ptr_d;
    logic [D-1:0] rd_ptr_q, rd_ptr_d;
    logic [D:0]   qcnt_q,   qcnt_d;

    // ------------------------------------------------------------------
    // Handshake and queue control
    // ------------------------------------------------------------------
    logic consume;
    logic out_free;
    logic take_start;
    logic in_window;
    logic q_empty;
    logic q_full;
    logic load;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    always_comb begin
        consume  = trig_q & w_done_i;
        out_free = ~trig_q | consume;

        // A start is taken from IDLE, or on the cycle the checksum word of
        // the previous frame is consumed (back-to-back frames).
        take_start = pix_frame_start_i &
                     ((state_q == ST_IDLE) | ((state_q == ST_SUM) & consume));

        // Pixels are accepted from the start cycle through the end cycle.
        in_window = take_start |
                    (((state_q == ST_HDR) | (state_q == ST_PIX)) & ~end_seen_q);

        q_empty = (qcnt_q == '0);
        q_full  = (qcnt_q == C_FULL);

        // While the header is pending the output register is only freed by
        // consuming it; in PIX an idle output register is free as well.
        load = 1'b0;
        if (state_q == ST_HDR) begin
            load = consume;
        end else if (state_q == ST_PIX) begin
            load = out_free;
        end

        pop      = load & ~q_empty;
        push_req = in_window & pix_valid_i;
        // A simultaneous pop makes room even when the queue is full.
        push     = push_req & (~q_full | pop);
        drop     = push_req & ~push;
    end

    // ------------------------------------------------------------------
    // Frame FSM and output word register
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        trig_d     = trig_q;
        data_d     = data_q;
        end_seen_d = end_seen_q;
        fcnt_d     = fcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (take_start) begin
                    state_d    = ST_HDR;
                    trig_d     = 1'b1;
                    data_d     = HDR;
                    end_seen_d = pix_frame_end_i;
                end
            end

            ST_HDR, ST_PIX: begin
                if (in_window && pix_frame_end_i) begin
                    end_seen_d = 1'b1;
                end
                if (load) begin
                    if (pop) begin
                        state_d = ST_PIX;
                        trig_d  = 1'b1;
                        data_d  = {4'h0, mem_q[rd_ptr_q]};
                    end else if (end_seen_q) begin
                        // end_seen_q means no more pixels can arrive, so an
                        // empty queue here means every pixel has been sent.
                        state_d = ST_CNT_LO;
                        trig_d  = 1'b1;
                        data_d  = pcnt_q[15:0];
                    end else begin
                        state_d = ST_PIX;
                        trig_d  = 1'b0;
                    end
                end
            end

            ST_CNT_LO: begin
                if (consume) begin
                    state_d = ST_CNT_HI;
                    data_d  = pcnt_q[31:16];
                end
            end

            ST_CNT_HI: begin
                if (consume) begin
                    state_d = ST_SUM;
                    data_d  = sum_q;
                end
            end

            ST_SUM: begin
                if (consume) begin
                    fcnt_d = fcnt_q + 16'd1;
                    if (take_start) begin
                        state_d    = ST_HDR;
                        trig_d     = 1'b1;
                        data_d     = HDR;
                        end_seen_d = pix_frame_end_i;
                    end else begin
                        state_d = ST_IDLE;
                        trig_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                trig_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel count, checksum and overflow
    // ------------------------------------------------------------------
    always_comb begin
        pcnt_d = pcnt_q;
        sum_d  = sum_q;
        ovf_d  = ovf_q;

        if (take_start) begin
            // Queue is empty on a start cycle, so the start pixel never drops.
            pcnt_d = push ? 32'd1 : 32'd0;
            sum_d  = push ? {4'h0, pix_data_i} : 16'd0;
            ovf_d  = 1'b0;
        end else begin
            if (push) begin
                pcnt_d = (pcnt_q == 32'hFFFF_FFFF) ? pcnt_q : pcnt_q + 32'd1;
                sum_d  = sum_q + {4'h0, pix_data_i};
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        qcnt_d   = qcnt_q;
        case ({push, pop})
            2'b10:   qcnt_d = qcnt_q + 1'b1;
            2'b01:   qcnt_d = qcnt_q - 1'b1;
            default: qcnt_d = qcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            data_q     <= 16'd0;
            end_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            fcnt_q     <= 16'd0;
            pcnt_q     <= 32'd0;
            sum_q      <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            qcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            data_q     <= data_d;
            end_seen_q <= end_seen_d;
            ovf_q      <= ovf_d;
            fcnt_q     <= fcnt_d;
            pcnt_q     <= pcnt_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            qcnt_q     <= qcnt_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pix_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_trigger_o   = trig_q;
    assign w_data_o      = data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign overflow_o    = ovf_q;
    assign frame_count_o = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pix_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pix_fifo_writer
// Purpose  : Self-checking bench for pix_fifo_writer. Directed frames are
//            compared word-for-word against streams built from the framing
//            rules; randomized frames are checked against stream properties
//            (header, pixel words are an in-order subset of those sent,
//            trailer count/checksum match the delivered pixels, overflow set
//            exactly when pixels went missing, handshake hold rules).
// Revision : 1.0  initial release
// ============================================================================
module tb_pix_fifo_writer;

    localparam logic [15:0] HDR = 16'hA5F0;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_frame_start;
    logic        pix_frame_end;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        w_trigger;
    logic [15:0] w_data;
    logic        w_done;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_count;

    logic        done_tie;
    logic        done_force;
    int          stall_pct;

    int          checks;
    int          errors;
    logic [15:0] exp_fc;

    logic [15:0] obs [$];
    logic [15:0] expq [$];
    logic [11:0] pxq [$];

    logic        prev_stall;
    logic [15:0] prev_data;

    always #5 clk = ~clk;

    always_comb w_done = done_tie ? w_trigger : done_force;

    pix_fifo_writer #(.D(2), .HDR(HDR)) dut (
        .clk               (clk),
        .rst               (rst),
        .pix_frame_start_i (pix_frame_start),
        .pix_frame_end_i   (pix_frame_end),
        .pix_valid_i       (pix_valid),
        .pix_data_i        (pix_data),
        .w_trigger_o       (w_trigger),
        .w_data_o          (w_data),
        .w_done_i          (w_done),
        .busy_o            (busy),
        .overflow_o        (overflow),
        .frame_count_o     (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Random FIFO back-pressure, updated once per cycle.
    always @(posedge clk) begin
        #1;
        done_force = ($urandom_range(99) >= stall_pct);
    end

    // Word collector and handshake hold monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_trigger", w_trigger, 1);
                check("hold_data", w_data, prev_data);
            end
            if (w_trigger && w_done) obs.push_back(w_data);
            prev_stall = w_trigger && !w_done;
            prev_data  = w_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_frame_start = 1'b0;
        pix_frame_end   = 1'b0;
        pix_valid       = 1'b0;
        pix_data        = 12'h000;
    endtask

    // Drives pxq as one frame. mid_start >= 1 raises an extra start pulse
    // alongside that pixel index.
    task automatic drive_frame(input int gap_pct, input int mid_start);
        int n;
        n = pxq.size();
        pix_frame_start = 1'b1;
        pix_valid       = (n > 0);
        pix_data        = (n > 0) ? pxq[0] : 12'h000;
        pix_frame_end   = (n <= 1);
        step();
        check("latency_hdr_trig", w_trigger, 1);
        check("latency_hdr_data", w_data, HDR);
        for (int i = 1; i < n; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                idle_inputs();
                step();
            end
            pix_frame_start = (i == mid_start);
            pix_valid       = 1'b1;
            pix_data        = pxq[i];
            pix_frame_end   = (i == n - 1);
            step();
            if (i == 1 && done_tie && gap_pct == 0)
                check("latency_px0", w_data, {4'h0, pxq[0]});
        end
        idle_inputs();
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 3000 && busy; k++) step();
        check(tag, busy, 0);
    endtask

    // Exact stream of a frame whose kept pixels are pxq[0 .. keep-1].
    task automatic build_exp(input int keep);
        logic [31:0] s;
        s = 0;
        expq.delete();
        expq.push_back(HDR);
        for (int i = 0; i < keep; i++) begin
            expq.push_back({4'h0, pxq[i]});
            s = s + pxq[i];
        end
        expq.push_back(keep[15:0]);
        expq.push_back(16'h0000);
        expq.push_back(s[15:0]);
    endtask

    task automatic check_exact(input string tag);
        check({tag, "_len"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++)
            check({tag, "_word"}, obs[i], expq[i]);
    endtask

    // Property check of the last frame in obs against the pixels sent (pxq).
    task automatic check_frame(input string tag);
        int          n;
        int          j;
        logic        ok;
        logic [31:0] s;
        exp_fc = exp_fc + 16'd1;
        check({tag, "_fcount"}, frame_count, exp_fc);
        check({tag, "_minlen"}, (obs.size() >= 4), 1);
        if (obs.size() >= 4) begin
            n = obs.size() - 4;
            check({tag, "_hdr"}, obs[0], HDR);
            check({tag, "_cnt"}, {obs[n+2], obs[n+1]}, n);
            s  = 0;
            j  = 0;
            ok = 1'b1;
            for (int k = 1; k <= n; k++) begin
                s = s + obs[k];
                while (j < pxq.size() && {4'h0, pxq[j]} != obs[k]) j++;
                if (j >= pxq.size()) ok = 1'b0;
                else j++;
            end
            check({tag, "_subseq"}, ok, 1);
            check({tag, "_sum"}, obs[n+3], s[15:0]);
            check({tag, "_ovf"}, overflow, (n != pxq.size()));
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_fc     = 16'd0;
        done_tie   = 1'b1;
        stall_pct  = 0;
        done_force = 1'b1;
        prev_stall = 1'b0;
        prev_data  = 16'h0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_trigger", w_trigger, 0);
        check("rst_data", w_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fcount", frame_count, 0);

        // Reset in the middle of a frame abandons it
        pix_frame_start = 1'b1;
        pix_valid       = 1'b1;
        pix_data        = 12'h111;
        step();
        pix_frame_start = 1'b0;
        pix_data        = 12'h222;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        check("midrst_trigger", w_trigger, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fcount", frame_count, 0);
        rst = 1'b0;
        step();
        obs.delete();
        pxq = '{12'h333, 12'h444, 12'h555};
        drive_frame(0, -1);
        wait_idle("midrst_done");
        build_exp(3);
        check_exact("midrst_new");
        check_frame("midrst_new");

        // Four pixels, w_done tied to w_trigger
        obs.delete();
        pxq = '{12'h123, 12'h456, 12'h789, 12'hABC};
        drive_frame(0, -1);
        wait_idle("basic_done");
        expq = '{16'hA5F0, 16'h0123, 16'h0456, 16'h0789, 16'h0ABC,
                 16'h0004, 16'h0000, 16'h17BE};
        check_exact("basic");
        check_frame("basic");

        // Zero-pixel frame: start and end in the same cycle
        obs.delete();
        pxq.delete();
        drive_frame(0, -1);
        wait_idle("zero_done");
        expq = '{16'hA5F0, 16'h0000, 16'h0000, 16'h0000};
        check_exact("zero");
        check_frame("zero");

        // Checksum wrap: 32 pixels of 0xFFF
        obs.delete();
        pxq.delete();
        for (int i = 0; i < 32; i++) pxq.push_back(12'hFFF);
        drive_frame(0, -1);
        wait_idle("wrap_done");
        build_exp(32);
        check_exact("wrap");
        check_frame("wrap");
        if (obs.size() == 36) begin
            check("wrap_cnt_lo", obs[33], 16'h0020);
            check("wrap_cnt_hi", obs[34], 16'h0000);
            check("wrap_sum", obs[35], 16'hFFE0);
        end

        // FIFO stalled for 12 cycles from start, 6 pixels back-to-back
        obs.delete();
        pxq.delete();
        for (int i = 0; i < 6; i++) pxq.push_back(12'($urandom_range(4095)));
        done_tie  = 1'b0;
        stall_pct = 100;
        drive_frame(0, -1);
        for (int i = 0; i < 6; i++) step();
        done_tie  = 1'b1;
        stall_pct = 0;
        wait_idle("stall_done");
        build_exp(4);
        check_exact("stall");
        check("stall_overflow", overflow, 1);
        check_frame("stall");

        // Randomized frames with back-pressure, gaps and stray starts
        for (int f = 0; f < 30; f++) begin
            int n;
            int mid;
            n = $urandom_range(24);
            obs.delete();
            pxq.delete();
            for (int i = 0; i < n; i++) pxq.push_back(12'($urandom_range(4095)));
            done_tie  = ($urandom_range(3) == 0);
            stall_pct = $urandom_range(70);
            mid       = (n >= 2 && $urandom_range(1) == 1) ? $urandom_range(n - 1, 1) : -1;
            drive_frame($urandom_range(40), mid);
            wait_idle("rand_done");
            check_frame("rand");
            done_tie  = 1'b1;
            stall_pct = 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
